// File: rtl/ex_mem_lsu.sv
// ex_mem_lsu: EX/MEM pipeline register with an integrated load/store unit.
//
// ALU results from EX pass to writeback with one cycle of latency. Loads
// and stores run one req/ack transaction on the data bus. While that
// transaction is outstanding, upstream is stalled. Load data is aligned
// and extended before it is written back.
//
// Build option: define LSU_TIMEOUT_EN to abort a bus transaction after
// TIMEOUT_CYCLES cycles without ack. The abort pulses bus_err. Without the
// macro, the unit waits for ack indefinitely and bus_err is tied low.
//
// Ports:
//   clk, reset              rising-edge clock; synchronous active-high reset
//   flush                   drop the instruction being latched (IDLE only)
//   ex_wr_addr/data/en      register writeback request from EX
//   ex_mem_op               memory op code (LB/LBU/LH/LHU/LW/SB/SH/SW, else none)
//   ex_mem_addr             effective address
//   ex_store_data           store data
//   stall_req               high while a bus transaction is outstanding
//   bus_req/we/addr/be/wdata  registered bus request, stable until ack
//   bus_ack, bus_rdata      bus completion and load data
//   wb_addr/data/en         writeback port
//   align_err               one-cycle pulse for a misaligned access
//   bus_err                 one-cycle pulse for a bus timeout
module ex_mem_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [4:0]  ex_wr_addr,
  input  logic [31:0] ex_wr_data,
  input  logic        ex_wr_en,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_store_data,
  output logic        stall_req,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        wb_en,
  output logic        align_err,
  output logic        bus_err
);

  typedef enum logic {IDLE, BUS} state_e;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd9,
    OP_SH   = 4'd10,
    OP_SW   = 4'd11
  } mem_op_e;

  state_e      state, state_nx;
  mem_op_e     op_dec, op_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        rd_en_q;
  logic        is_mem, is_store, misaligned;
  logic [3:0]  be_nx;
  logic [31:0] wdata_nx;
  logic [31:0] rdata_shifted;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic        timeout_hit;

  // Unlisted op codes decode to OP_NONE and behave as ALU pass-through.
  always_comb begin
    op_dec = OP_NONE;
    case (ex_mem_op)
      OP_LB:   op_dec = OP_LB;
      OP_LBU:  op_dec = OP_LBU;
      OP_LH:   op_dec = OP_LH;
      OP_LHU:  op_dec = OP_LHU;
      OP_LW:   op_dec = OP_LW;
      OP_SB:   op_dec = OP_SB;
      OP_SH:   op_dec = OP_SH;
      OP_SW:   op_dec = OP_SW;
      default: op_dec = OP_NONE;
    endcase
  end

  always_comb begin
    is_mem     = (op_dec != OP_NONE);
    is_store   = (op_dec == OP_SB) || (op_dec == OP_SH) || (op_dec == OP_SW);
    misaligned = 1'b0;
    be_nx      = 4'b1111;
    wdata_nx   = '0;
    case (op_dec)
      OP_LB, OP_LBU, OP_SB: be_nx = 4'b0001 << ex_mem_addr[1:0];
      OP_LH, OP_LHU, OP_SH: begin
        be_nx      = ex_mem_addr[1] ? 4'b1100 : 4'b0011;
        misaligned = ex_mem_addr[0];
      end
      OP_LW, OP_SW: misaligned = |ex_mem_addr[1:0];
      default: ;
    endcase
    case (op_dec)
      OP_SB:   wdata_nx = {4{ex_store_data[7:0]}};
      OP_SH:   wdata_nx = {2{ex_store_data[15:0]}};
      OP_SW:   wdata_nx = ex_store_data;
      default: wdata_nx = '0;
    endcase
  end

  // Pick the addressed lane out of the returned word, then extend it.
  always_comb begin
    rdata_shifted = bus_rdata >> {off_q, 3'b000};
    byte_lane     = rdata_shifted[7:0];
    half_lane     = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (op_q)
      OP_LB:   load_data = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  load_data = {24'd0, byte_lane};
      OP_LH:   load_data = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  load_data = {16'd0, half_lane};
      default: load_data = bus_rdata;
    endcase
  end

  assign stall_req = (state == BUS);
  assign bus_req   = (state == BUS);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (!flush && is_mem && !misaligned) state_nx = BUS;
      BUS:  if (bus_ack || timeout_hit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= OP_NONE;
      off_q     <= '0;
      rd_q      <= '0;
      rd_en_q   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      wb_addr   <= '0;
      wb_data   <= '0;
      wb_en     <= 1'b0;
      align_err <= 1'b0;
    end else begin
      align_err <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            wb_en <= 1'b0;
          end else if (!is_mem) begin
            wb_addr <= ex_wr_addr;
            wb_data <= ex_wr_data;
            wb_en   <= ex_wr_en;
          end else if (misaligned) begin
            wb_en     <= 1'b0;
            align_err <= 1'b1;
          end else begin
            wb_en     <= 1'b0;
            op_q      <= op_dec;
            off_q     <= ex_mem_addr[1:0];
            rd_q      <= ex_wr_addr;
            rd_en_q   <= ex_wr_en;
            bus_we    <= is_store;
            bus_addr  <= {ex_mem_addr[31:2], 2'b00};
            bus_be    <= be_nx;
            bus_wdata <= wdata_nx;
          end
        end
        BUS: begin
          if (bus_ack) begin
            if (bus_we) begin
              wb_en <= 1'b0;
            end else begin
              wb_addr <= rd_q;
              wb_data <= load_data;
              wb_en   <= rd_en_q;
            end
          end else if (timeout_hit) begin
            wb_en <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);

  logic [CNT_W-1:0] wait_cnt;

  // The counter holds the number of ack-less BUS cycles already seen.
  // Expiry is the cycle that would bring it to TIMEOUT_CYCLES. An ack in
  // that same cycle still completes normally.
  assign timeout_hit = (state == BUS) && !bus_ack &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      bus_err <= timeout_hit;
      if (state != BUS)  wait_cnt <= '0;
      else if (!bus_ack) wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign bus_err            = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_lsu.sv
// Self-checking bench for ex_mem_lsu.
// It runs a table of directed vectors, then randomized instructions that
// are checked against a byte-lane reference model. It ends with
// hand-written reset and timeout sequences.
module tb_ex_mem_lsu;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [4:0]  ex_wr_addr;
  logic [31:0] ex_wr_data;
  logic        ex_wr_en;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_addr, ex_store_data;
  logic        stall_req, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_en, align_err, bus_err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  ex_mem_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data), .ex_wr_en(ex_wr_en),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .stall_req(stall_req), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_en(wb_en),
    .align_err(align_err), .bus_err(bus_err)
  );

  // kind: 0 = no bus access (ALU result or bubble), 1 = bus access, 2 = misaligned
  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr, sdata, rdata, alu;
    logic [4:0]  rd;
    logic        en, flush;
    int unsigned delay;
    int unsigned kind;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wb_en;
    logic [31:0] wb_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, sdata, rdata,
                              input logic [4:0] rd, input logic en, input logic [31:0] alu,
                              input int unsigned delay, input logic fl, input int unsigned kind,
                              input logic we, input logic [3:0] be, input logic [31:0] wdata,
                              input logic wbe, input logic [31:0] wbd);
    vec_t v;
    v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.rd = rd; v.en = en;
    v.alu = alu; v.delay = delay; v.flush = fl; v.kind = kind; v.we = we; v.be = be;
    v.wdata = wdata; v.wb_en = wbe; v.wb_data = wbd;
    return v;
  endfunction

  // Reference model: an access of size bytes at offset o touches lanes
  // o..o+size-1. Store data repeats every size bytes across the word. A load
  // shifts the word down by o bytes, masks it, and optionally sign-extends.
  function automatic vec_t model(input logic [3:0] op, input logic [31:0] addr, sdata, rdata,
                                 input logic [4:0] rd, input logic en, input logic [31:0] alu,
                                 input int unsigned delay, input logic fl);
    vec_t v;
    int unsigned size, o;
    bit sgn, st;
    longint unsigned val, mask;
    v = mk(op, addr, sdata, rdata, rd, en, alu, delay, fl, 0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    size = 0; sgn = 0; st = 0;
    case (op)
      4'd1:  begin size = 1; sgn = 1; end
      4'd2:  size = 1;
      4'd3:  begin size = 2; sgn = 1; end
      4'd4:  size = 2;
      4'd5:  size = 4;
      4'd9:  begin size = 1; st = 1; end
      4'd10: begin size = 2; st = 1; end
      4'd11: begin size = 4; st = 1; end
      default: size = 0;
    endcase
    o = addr % 4;
    if (fl) begin
      v.kind = 0; v.wb_en = 1'b0;
    end else if (size == 0) begin
      v.kind = 0; v.wb_en = en; v.wb_data = alu;
    end else if ((addr % size) != 0) begin
      v.kind = 2;
    end else begin
      v.kind = 1;
      v.we = st;
      for (int i = 0; i < 4; i++) begin
        v.be[i] = (i >= int'(o)) && (i < int'(o + size));
        v.wdata[8*i +: 8] = 8'((sdata >> (8 * (i % size))) & 32'hff);
      end
      mask = (64'd1 << (8 * size)) - 1;
      val  = (longint'(rdata) >> (8 * o)) & mask;
      if (sgn && ((val >> (8 * size - 1)) & 1) == 1) val = val | ~mask;
      v.wb_data = val[31:0];
      v.wb_en   = st ? 1'b0 : en;
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    ex_mem_op = v.op; ex_mem_addr = v.addr; ex_store_data = v.sdata;
    ex_wr_addr = v.rd; ex_wr_en = v.en; ex_wr_data = v.alu; flush = v.flush;
    bus_ack = 1'($urandom);  // a stray ack while idle must be ignored
    bus_rdata = $urandom;
    step;
    flush = 1'b0; bus_ack = 1'b0;
    if (v.kind == 0) begin
      check({tag, " stall"}, 32'(stall_req), 32'd0);
      check({tag, " bus_req"}, 32'(bus_req), 32'd0);
      check({tag, " wb_en"}, 32'(wb_en), 32'(v.wb_en));
      if (v.wb_en) begin
        check({tag, " wb_addr"}, 32'(wb_addr), 32'(v.rd));
        check({tag, " wb_data"}, wb_data, v.wb_data);
      end
    end else if (v.kind == 2) begin
      check({tag, " align_err"}, 32'(align_err), 32'd1);
      check({tag, " bus_req"}, 32'(bus_req), 32'd0);
      check({tag, " wb_en"}, 32'(wb_en), 32'd0);
      ex_mem_op = 4'd0; ex_wr_en = 1'b0;
      step;
      check({tag, " align_err pulse"}, 32'(align_err), 32'd0);
    end else begin
      // EX inputs and flush are ignored while the bus is busy
      ex_mem_op = 4'($urandom); ex_wr_data = $urandom; ex_wr_en = 1'b1;
      ex_mem_addr = $urandom; flush = 1'($urandom);
      for (int i = 0; i <= int'(v.delay); i++) begin
        check({tag, " bus_req"}, 32'(bus_req), 32'd1);
        check({tag, " stall"}, 32'(stall_req), 32'd1);
        check({tag, " bus_we"}, 32'(bus_we), 32'(v.we));
        check({tag, " bus_addr"}, bus_addr, v.addr & 32'hFFFF_FFFC);
        check({tag, " bus_be"}, 32'(bus_be), 32'(v.be));
        if (v.we) check({tag, " bus_wdata"}, bus_wdata, v.wdata);
        check({tag, " wb_en busy"}, 32'(wb_en), 32'd0);
        if (i == int'(v.delay)) begin bus_ack = 1'b1; bus_rdata = v.rdata; end
        else begin bus_ack = 1'b0; bus_rdata = $urandom; end
        step;
      end
      bus_ack = 1'b0; flush = 1'b0;
      check({tag, " bus_req done"}, 32'(bus_req), 32'd0);
      check({tag, " stall done"}, 32'(stall_req), 32'd0);
      check({tag, " wb_en"}, 32'(wb_en), 32'(v.wb_en));
      if (v.wb_en) begin
        check({tag, " wb_addr"}, 32'(wb_addr), 32'(v.rd));
        check({tag, " wb_data"}, wb_data, v.wb_data);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    logic [3:0] ops [11];
    logic [31:0] a;

    reset = 1'b1; flush = 1'b0; ex_wr_addr = '0; ex_wr_data = '0; ex_wr_en = 1'b0;
    ex_mem_op = '0; ex_mem_addr = '0; ex_store_data = '0; bus_ack = 1'b0; bus_rdata = '0;
    step; step;
    check("reset wb_en", 32'(wb_en), 32'd0);
    check("reset wb_data", wb_data, 32'd0);
    check("reset bus_req", 32'(bus_req), 32'd0);
    check("reset stall", 32'(stall_req), 32'd0);
    check("reset align_err", 32'(align_err), 32'd0);
    check("reset bus_err", 32'(bus_err), 32'd0);
    reset = 1'b0;

    //           op     addr          sdata         rdata         rd  en   alu           dly fl kind we  be       wdata         wbe  wbdata
    tbl.push_back(mk(4'd0,  32'h0,        32'h0,        32'h0,        5,  1,  32'h1234_5678, 0, 0, 0, 0, 4'b0000, 32'h0,        1, 32'h1234_5678));
    tbl.push_back(mk(4'd1,  32'h103,      32'h0,        32'h80FF_0000, 7, 1,  32'h0,        2, 0, 1, 0, 4'b1000, 32'h0,        1, 32'hFFFF_FF80));
    tbl.push_back(mk(4'd10, 32'h202,      32'h0000_ABCD, 32'h0,       3,  1,  32'h0,        1, 0, 1, 1, 4'b1100, 32'hABCD_ABCD, 0, 32'h0));
    tbl.push_back(mk(4'd5,  32'h301,      32'h0,        32'h0,        4,  1,  32'h0,        0, 0, 2, 0, 4'b0000, 32'h0,        0, 32'h0));
    tbl.push_back(mk(4'd0,  32'h0,        32'h0,        32'h0,        9,  1,  32'hDEAD_0001, 0, 1, 0, 0, 4'b0000, 32'h0,        0, 32'h0));
    tbl.push_back(mk(4'd5,  32'h40,       32'h0,        32'h0,        9,  1,  32'h0,        0, 1, 0, 0, 4'b0000, 32'h0,        0, 32'h0));
    tbl.push_back(mk(4'd2,  32'h101,      32'h0,        32'h1234_80AB, 10, 1, 32'h0,        0, 0, 1, 0, 4'b0010, 32'h0,        1, 32'h0000_0080));
    tbl.push_back(mk(4'd4,  32'h102,      32'h0,        32'h8765_4321, 11, 1, 32'h0,        0, 0, 1, 0, 4'b1100, 32'h0,        1, 32'h0000_8765));
    tbl.push_back(mk(4'd3,  32'h100,      32'h0,        32'h0000_F00D, 12, 1, 32'h0,        1, 0, 1, 0, 4'b0011, 32'h0,        1, 32'hFFFF_F00D));
    tbl.push_back(mk(4'd5,  32'h400,      32'h0,        32'hDEAD_BEEF, 13, 1, 32'h0,        0, 0, 1, 0, 4'b1111, 32'h0,        1, 32'hDEAD_BEEF));
    tbl.push_back(mk(4'd9,  32'h001,      32'h1234_56A5, 32'h0,       14, 1,  32'h0,        0, 0, 1, 1, 4'b0010, 32'hA5A5_A5A5, 0, 32'h0));
    tbl.push_back(mk(4'd11, 32'h004,      32'hCAFE_F00D, 32'h0,       15, 1,  32'h0,        0, 0, 1, 1, 4'b1111, 32'hCAFE_F00D, 0, 32'h0));
    tbl.push_back(mk(4'd10, 32'h003,      32'h0,        32'h0,        16, 1,  32'h0,        0, 0, 2, 0, 4'b0000, 32'h0,        0, 32'h0));
    tbl.push_back(mk(4'd7,  32'h0,        32'h0,        32'h0,        17, 1,  32'h0BAD_C0DE, 0, 0, 0, 0, 4'b0000, 32'h0,       1, 32'h0BAD_C0DE));
    tbl.push_back(mk(4'd5,  32'h800,      32'h0,        32'h1111_2222, 18, 0, 32'h0,        0, 0, 1, 0, 4'b1111, 32'h0,        0, 32'h0));

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11, 4'd6, 4'd13};
    for (int n = 0; n < 300; n++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      v = model(ops[$urandom_range(0, 10)], a, $urandom, $urandom, 5'($urandom), 1'($urandom),
                $urandom, $urandom_range(0, 3), $urandom_range(0, 7) == 0);
      run_vec(v, $sformatf("rnd%0d", n));
    end

    // Reset while a transaction is outstanding
    run_vec(mk(4'd0, 32'h0, 32'h0, 32'h0, 31, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 4'd0, 32'h0, 1, 32'hFFFF_FFFF), "rst pre");
    ex_mem_op = 4'd11; ex_mem_addr = 32'h500; ex_store_data = 32'h5555_AAAA; ex_wr_en = 1'b1;
    step;
    check("rst busy bus_req", 32'(bus_req), 32'd1);
    reset = 1'b1; ex_mem_op = 4'd0; ex_wr_en = 1'b0;
    step;
    check("rst bus_req", 32'(bus_req), 32'd0);
    check("rst stall", 32'(stall_req), 32'd0);
    check("rst wb_en", 32'(wb_en), 32'd0);
    check("rst wb_addr", 32'(wb_addr), 32'd0);
    check("rst wb_data", wb_data, 32'd0);
    check("rst bus_addr", bus_addr, 32'd0);
    check("rst bus_be", 32'(bus_be), 32'd0);
    check("rst bus_we", 32'(bus_we), 32'd0);
    check("rst bus_wdata", bus_wdata, 32'd0);
    reset = 1'b0;
    bus_ack = 1'b1;
    step;
    bus_ack = 1'b0;
    check("rst no wb", 32'(wb_en), 32'd0);

    // Bus wait without ack
    ex_mem_op = 4'd5; ex_mem_addr = 32'h600; ex_wr_addr = 5'd20; ex_wr_en = 1'b1;
    step;
    ex_mem_op = 4'd0; ex_wr_en = 1'b0; ex_wr_data = '0;
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      check("to bus_req", 32'(bus_req), 32'd1);
      check("to bus_err early", 32'(bus_err), 32'd0);
      step;
    end
    check("to bus_req drop", 32'(bus_req), 32'd0);
    check("to stall drop", 32'(stall_req), 32'd0);
    check("to bus_err", 32'(bus_err), 32'd1);
    check("to wb_en", 32'(wb_en), 32'd0);
    step;
    check("to bus_err pulse", 32'(bus_err), 32'd0);
`else
    for (int i = 0; i < 20; i++) begin
      check("wait bus_req", 32'(bus_req), 32'd1);
      step;
    end
    check("wait bus_err", 32'(bus_err), 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'h0F0F_1234;
    step;
    bus_ack = 1'b0;
    check("wait bus_req drop", 32'(bus_req), 32'd0);
    check("wait wb_en", 32'(wb_en), 32'd1);
    check("wait wb_addr", 32'(wb_addr), 32'd20);
    check("wait wb_data", wb_data, 32'h0F0F_1234);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_lsu.md
Name: ex_mem_lsu

Overview:
- EX/MEM pipeline register combined with a load/store unit, directly downstream of the EX stage.
- Latches EX results (write address, data, enable) and memory-op info each cycle.
- Passes ALU results to writeback with 1-cycle latency.
- For loads/stores: runs a req/ack transaction on the data bus, stalls upstream until it completes, and aligns/extends load data before writeback.

Parameters:
TIMEOUT_CYCLES, 255, bus cycles waited before abort (used only with LSU_TIMEOUT_EN)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
flush  input  1  discard instruction being latched this cycle (ignored in BUS state)
ex_wr_addr  input  5  destination register from EX
ex_wr_data  input  32  ALU result from EX
ex_wr_en  input  1  register write enable from EX
ex_mem_op  input  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 9 SB, 10 SH, 11 SW; other codes = NONE
ex_mem_addr  input  32  effective address
ex_store_data  input  32  store data (rt)
stall_req  output  1  upstream must hold EX inputs while high
bus_req  output  1  bus request
bus_we  output  1  1 = store
bus_addr  output  32  word address, bits[1:0] forced 0
bus_be  output  4  byte enables, little-endian lanes
bus_wdata  output  32  store data replicated into lanes
bus_ack  input  1  transaction complete; valid only while bus_req high
bus_rdata  input  32  load data, valid with bus_ack
wb_addr  output  5  writeback register
wb_data  output  32  writeback data
wb_en  output  1  writeback enable
align_err  output  1  1-cycle pulse, misaligned access
bus_err  output  1  1-cycle pulse, bus timeout (LSU_TIMEOUT_EN only)

Behaviour:
- Reset: state IDLE; all outputs 0; hold registers 0. Reset mid-transaction drops bus_req the next cycle with no writeback.
- States: IDLE, BUS.
- IDLE, each edge:
  - flush=1: latch a bubble (wb_en<=0, op NONE).
  - op NONE: wb_addr<=ex_wr_addr, wb_data<=ex_wr_data, wb_en<=ex_wr_en; stay IDLE.
  - memory op, aligned: capture address, store data, op and write address/enable; wb_en<=0; go to BUS.
  - memory op, misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): no bus access; wb_en<=0; align_err pulses next cycle; stay IDLE.
- BUS:
  - bus_req=1 and stall_req=1. bus_we/addr/be/wdata are registered and stable until ack.
  - EX inputs and flush are ignored.
  - bus_be: byte = 1<<addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
  - bus_wdata: SB replicates byte x4; SH replicates half x2; SW passes data through.
- BUS, cycle with bus_ack=1:
  - Next edge: state IDLE, bus_req=0, stall_req=0.
  - Loads: wb_data = selected lane, sign-extended (LB/LH) or zero-extended (LBU/LHU); LW = full word. wb_en = latched ex_wr_en; wb_addr = latched addr.
  - Stores: wb_en=0.
- stall_req is combinational: (state==BUS).
  - Minimum load-use latency: inputs at cycle N, bus_req from N+1, ack at the earliest in N+1, wb valid at N+2.
- bus_ack while bus_req=0: ignored.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - 8..16-bit counter clears on entry to BUS and increments each BUS cycle without ack.
  - On reaching TIMEOUT_CYCLES: return to IDLE, bus_req=0, wb_en=0, bus_err pulses 1 cycle.
  - Ack in the same cycle as expiry wins.
- Undefined: no counter; BUS waits indefinitely; bus_err tied 0.

Test Plan:
- ALU pass-through: op NONE, wr_addr=5, data=0x1234_5678, en=1 -> next cycle wb_addr=5, wb_data=0x12345678, wb_en=1; stall_req=0 throughout.
- LB sign: addr=0x103, ack after 3 cycles with rdata=0x80FF_0000 -> bus_be=1000 for 3 cycles with stall_req=1; then wb_data=0xFFFFFF80, wb_en=1.
- SH: addr=0x202, store_data=0x0000_ABCD -> bus_we=1, bus_addr=0x200, bus_be=1100, bus_wdata=0xABCDABCD; after ack wb_en=0.
- Misaligned LW: addr=0x301 -> bus_req stays 0, align_err=1 for one cycle, wb_en=0.
- Reset/flush: reset asserted in BUS -> next cycle bus_req=0, stall_req=0, all outputs 0; flush with op NONE in IDLE -> wb_en=0.
- Timeout (LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4): LW with no ack -> bus_req low after 4 BUS cycles, bus_err pulse, wb_en=0.
